// File: rtl/debug_reply_tx.sv
// Serial reply transmitter for the debug command path: formats one short ASCII
// reply per request and shifts it out as back-to-back 8N1 frames on TX.
module debug_reply_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BaudRate = 115200
) (
    input  logic       MainCLK,
    input  logic       RSTn,
    input  logic       Start,
    input  logic [1:0] Mode,
    input  logic [7:0] Data,
    output logic       Busy,
    output logic       Done,
    output logic       TX,
    output logic [1:0] dbg_state
);

    localparam int DIV = CLK_FREQ / BaudRate;
    localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (DIV < 2) begin : g_div_check
        $error("debug_reply_tx: CLK_FREQ/BaudRate must be at least 2");
    end

    // Request handshake: a request is taken on any rising edge with Start=1
    // while Busy=0; Start, Mode and Data are don't-care while Busy=1.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [2:0]      char_idx;
    logic [1:0]      mode_q;
    logic [7:0]      data_q;
    logic [7:0]      cur_char;
    logic [2:0]      last_idx;
    logic [2:0]      next_bit;
    logic            bit_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10) c = 8'h30 + {4'h0, n};
        else           c = 8'h41 + {4'h0, n} - 8'd10;
        return c;
    endfunction

    function automatic logic [7:0] msg_char(input logic [1:0] m, input logic [7:0] d,
                                            input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h0A;
        case (m)
            2'b00: c = d;
            2'b01: begin
                case (idx)
                    3'd0:    c = hex_ascii(d[7:4]);
                    3'd1:    c = hex_ascii(d[3:0]);
                    3'd2:    c = 8'h0D;
                    default: c = 8'h0A;
                endcase
            end
            2'b10: begin
                case (idx)
                    3'd0:    c = 8'h45;
                    3'd1:    c = 8'h52;
                    3'd2:    c = 8'h52;
                    3'd3:    c = 8'h0D;
                    default: c = 8'h0A;
                endcase
            end
            default: c = (idx == 3'd0) ? 8'h0D : 8'h0A;
        endcase
        return c;
    endfunction

    // Message length comes from the latched mode only.
    always_comb begin
        last_idx = 3'd1;
        case (mode_q)
            2'b00:   last_idx = 3'd0;
            2'b01:   last_idx = 3'd3;
            2'b10:   last_idx = 3'd4;
            default: last_idx = 3'd1;
        endcase
        cur_char = msg_char(mode_q, data_q, char_idx);
        next_bit = bit_idx + 3'd1;
        bit_end  = (baud_cnt == CNT_MAX);
    end

    always_ff @(posedge MainCLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            TX       <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            char_idx <= 3'd0;
            mode_q   <= 2'b00;
            data_q   <= 8'h00;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        mode_q   <= Mode;
                        data_q   <= Data;
                        char_idx <= 3'd0;
                        bit_idx  <= 3'd0;
                        baud_cnt <= '0;
                        Busy     <= 1'b1;
                        TX       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        TX       <= cur_char[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            TX      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= next_bit;
                            TX      <= cur_char[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (char_idx == last_idx) begin
                            char_idx <= 3'd0;
                            Busy     <= 1'b0;
                            Done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // Next start bit follows the stop bit with no gap.
                            char_idx <= char_idx + 3'd1;
                            TX       <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/debug_reply_tx.md
# debug_reply_tx

- Serial reply transmitter for the debug command path; it is the transmit end of the RS-232 link whose receive end feeds the debug commander.
- Accepts one reply request per handshake and formats it into a short ASCII message: a raw byte, a two-digit hex byte plus CR LF, the text "ERR" plus CR LF, or a bare CR LF.
- Sends the message as back-to-back 8N1 frames on TX, clocked directly from MainCLK by an internal baud counter, with no separate baud clock.

## Interface

- CLK_FREQ, 50_000_000: MainCLK frequency in Hz.
- BaudRate, 115200: serial bit rate.
- DIV is derived as CLK_FREQ/BaudRate, integer truncated. DIV < 2 is illegal (elaboration error).

- MainCLK  in  1  system clock; all state on rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- Start  in  1  request strobe; sampled only while Busy=0.
- Mode  in  2  message type: 00 raw, 01 hex+CRLF, 10 "ERR"+CRLF, 11 CRLF only.
- Data  in  8  payload byte; used by modes 00 and 01.
- Busy  out  1  high while a message is in flight.
- Done  out  1  one-cycle pulse when the last stop bit completes.
- TX  out  1  serial line; idles high.

## Operation

- **Request latch:** on a rising edge with Start=1 and Busy=0, Mode and Data are captured. Changes on Mode, Data or Start while Busy=1 are ignored.
- **Message character sequences:**
  - Mode 00: Data (1 char).
  - Mode 01: hex(Data[7:4]), hex(Data[3:0]), 0x0D, 0x0A (4 chars).
  - Mode 10: 0x45, 0x52, 0x52, 0x0D, 0x0A (5 chars).
  - Mode 11: 0x0D, 0x0A (2 chars).
- **Hex digits:** uppercase. Nibble 0-9 maps to 0x30+n; nibble A-F maps to 0x41+(n-10).
- **Frame format:** start bit 0, then 8 data bits LSB first, then stop bit 1. That is 10 bit periods per character, and each bit period is exactly DIV clocks.
- **Character spacing:** characters within a message are back-to-back; the next start bit follows the stop bit with no gap.
- **FSM states:**
  - IDLE → START on an accepted request.
  - START → DATA after DIV clocks.
  - DATA → STOP after 8×DIV clocks; the bit index runs 0..7.
  - STOP → START if characters remain, otherwise → IDLE with Done pulsed.
- **Character index:** a 3-bit index selects the current character. Message length is fixed by the latched Mode, never by live Mode.
- **Reset:** RSTn=0 forces immediately, without waiting for a clock:
  - TX=1, Busy=0, Done=0, state IDLE;
  - baud counter, bit index and character index all 0.
  - Reset in mid-message aborts it; no Done is produced for the aborted message.

## Timing

- Let k be the edge that accepts a request. After edge k: Busy=1 and TX=0 (start bit of character 0). Latency from the accepting edge to the TX falling edge is 0 cycles.
- Let N = chars×10×DIV. After edge k+N: Busy=0, Done=1, TX=1. After edge k+N+1: Done=0.
- Bit j of character c is driven on TX for the interval after edges k+(10c+j)·DIV through k+(10c+j+1)·DIV−1.
- Start=1 during the Done cycle is accepted at edge k+N+1. Consecutive messages are therefore separated by exactly one idle-high clock.
- Busy and Done are registered outputs. TX is registered and glitch-free.
- Reset values: TX=1, Busy=0, Done=0.

## Test plan

Bench parameters for all scenarios: CLK_FREQ=1_000_000, BaudRate=100_000, giving DIV=10.

- Reset: hold RSTn=0, then release → TX=1, Busy=0, Done=0; no transitions for 200 cycles with Start=0.
- Mode 00, Data=0x55 → TX bit sequence 0,1,0,1,0,1,0,1,0,1, each level for 10 cycles; Busy high for exactly 100 cycles; a single Done pulse coincident with Busy falling.
- Mode 01, Data=0x3F → decoded characters 0x33, 0x46, 0x0D, 0x0A; Busy for 400 cycles; no gap between frames.
- Mode 10, with Start pulsed and Mode=00, Data=0xFF driven every 37 cycles while Busy → characters exactly 0x45, 0x52, 0x52, 0x0D, 0x0A; Busy for 500 cycles; the extra Start pulses are ignored.
- Mode 01, Data=0xA0, with RSTn pulsed low at cycle 150 (inside character 1) → TX=1 and Busy=0 asynchronously; no Done. A following mode-11 request then sends 0x0D, 0x0A normally in 200 cycles.
- Start held high with Mode=11 → messages repeat; exactly one TX-high idle cycle between each Done pulse and the next start bit; every Busy period is 200 cycles.
